pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage ARM pipeline. Drives the freeze and flush inputs of the PC register and the IF/ID pipeline register, and the bubble/freeze controls of the later stage registers. Resolves three event sources: RAW data hazards at ID, taken branches resolved in EX, and multi-cycle data-memory waits in MEM. Contains a memory-wait state machine with timeout detection and a saturating stall performance counter.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 14 +
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared state encoding and register-number types
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 4;

  typedef logic [REG_W-1:0] reg_num_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipeline_hazard_ctrl_pkg::*;

  reg_num_t         id_src1;
  reg_num_t         id_src2;
  logic             id_src1_valid;
  logic             id_src2_valid;
  reg_num_t         ex_dest;
  logic             ex_wb_en;
  logic             ex_mem_r_en;
  reg_num_t         mem_dest;
  logic             mem_wb_en;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_freeze;
  logic             if_freeze;
  logic             if_flush;
  logic             id_flush;
  logic             pipe_freeze;
  logic             hazard;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_src1, id_src2, id_src1_valid, id_src2_valid,
    output ex_dest, ex_wb_en, ex_mem_r_en, mem_dest, mem_wb_en,
    output ex_branch_taken, mem_req, mem_ready,
    input  pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze,
    input  hazard, mem_timeout, stall_count
  );

  modport slave (
    input  id_src1, id_src2, id_src1_valid, id_src2_valid,
    input  ex_dest, ex_wb_en, ex_mem_r_en, mem_dest, mem_wb_en,
    input  ex_branch_taken, mem_req, mem_ready,
    output pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze,
    output hazard, mem_timeout, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - RAW comparator at ID; FORWARDING_EN selects load-use-only detection
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  reg_num_t id_src1_i,
  input  reg_num_t id_src2_i,
  input  logic     id_src1_valid_i,
  input  logic     id_src2_valid_i,
  input  reg_num_t ex_dest_i,
  input  logic     ex_wb_en_i,
  input  logic     ex_mem_r_en_i,
  input  reg_num_t mem_dest_i,
  input  logic     mem_wb_en_i,
  output logic     hazard_o
);

  logic src1_hit;
  logic src2_hit;

`ifdef FORWARDING_EN
  // Forwarding covers ALU results; only a load in EX cannot be bypassed in time.
  logic unused_mem;
  assign unused_mem = ^{mem_dest_i, mem_wb_en_i};
  assign src1_hit = ex_wb_en_i && ex_mem_r_en_i && (ex_dest_i == id_src1_i);
  assign src2_hit = ex_wb_en_i && ex_mem_r_en_i && (ex_dest_i == id_src2_i);
`else
  logic unused_ld;
  assign unused_ld = ex_mem_r_en_i;
  assign src1_hit = (ex_wb_en_i && (ex_dest_i == id_src1_i)) ||
                    (mem_wb_en_i && (mem_dest_i == id_src1_i));
  assign src2_hit = (ex_wb_en_i && (ex_dest_i == id_src2_i)) ||
                    (mem_wb_en_i && (mem_dest_i == id_src2_i));
`endif

  assign hazard_o = (id_src1_valid_i && src1_hit) || (id_src2_valid_i && src2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with memory-wait FSM and stall counter (FORWARDING_EN in hazard_detect)
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic hazard_raw;
  logic mem_wait;
  logic pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze;

  hazard_detect u_hazard_detect (
    .id_src1_i       (bus.id_src1),
    .id_src2_i       (bus.id_src2),
    .id_src1_valid_i (bus.id_src1_valid),
    .id_src2_valid_i (bus.id_src2_valid),
    .ex_dest_i       (bus.ex_dest),
    .ex_wb_en_i      (bus.ex_wb_en),
    .ex_mem_r_en_i   (bus.ex_mem_r_en),
    .mem_dest_i      (bus.mem_dest),
    .mem_wb_en_i     (bus.mem_wb_en),
    .hazard_o        (hazard_raw)
  );

  assign mem_wait = ((state_q == ST_RUN) && bus.mem_req && !bus.mem_ready) ||
                    ((state_q == ST_MEM_WAIT) && !bus.mem_ready) ||
                    (state_q == ST_ERROR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          // wait_cnt counts wait cycles already elapsed; this one is the MAX_WAIT-th.
          if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    mem_timeout_d = mem_timeout_q || (state_d == ST_ERROR);
    stall_cnt_d   = stall_cnt_q;
    if (pc_freeze && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Priority: memory wait holds everything, then branch flush, then hazard bubble.
  always_comb begin
    pc_freeze   = 1'b0;
    if_freeze   = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        pc_freeze   = 1'b1;
        if_freeze   = 1'b1;
        pipe_freeze = 1'b1;
      end else if (bus.ex_branch_taken) begin
        if_flush = 1'b1;
        id_flush = 1'b1;
      end else if (hazard_raw) begin
        pc_freeze = 1'b1;
        if_freeze = 1'b1;
        id_flush  = 1'b1;
      end
    end
  end

  assign bus.pc_freeze   = pc_freeze;
  assign bus.if_freeze   = if_freeze;
  assign bus.if_flush    = if_flush;
  assign bus.id_flush    = id_flush;
  assign bus.pipe_freeze = pipe_freeze;
  assign bus.hazard      = hazard_raw && !rst;
  assign bus.mem_timeout = mem_timeout_q && !rst;
  assign bus.stall_count = rst ? '0 : stall_cnt_q;

endmodule
